// File: rtl/soc_irq_pkg.sv
// Shared interrupt definitions: line count and the source-latch register map.
// Also imported by the interrupt controller.
package soc_irq_pkg;
  localparam int IRQ_NUM = 8;

  localparam logic [1:0] IRQ_ADR_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ADR_MASK    = 2'd1;
  localparam logic [1:0] IRQ_ADR_MODE    = 2'd2;
  localparam logic [1:0] IRQ_ADR_STATUS  = 2'd3;
endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: synchroniser chain, one-cycle delayed copy, rising-edge detect.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic s_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   s_d_q, s_d_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], raw_i};
    s_d_d   = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      s_d_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      s_d_q   <= s_d_d;
    end
  end

  // s_d tracks s in both modes, so a MODE flip never fabricates an edge.
  assign s_o    = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~s_d_q;
endmodule

// File: rtl/irq_source_latch.sv
// Interrupt source conditioning: per-line sync/edge detect, pending latch, mask,
// and a Wishbone register file (PENDING w1c, MASK, MODE, STATUS).
module irq_source_latch
  import soc_irq_pkg::*;
#(
  parameter int NUM_IRQ     = IRQ_NUM,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               CYC_I,
  input  logic               STB_I,
  input  logic               WE_I,
  input  logic [1:0]         ADR_I,
  input  logic [NUM_IRQ-1:0] DAT_I,
  output logic [NUM_IRQ-1:0] DAT_O,
  output logic               ACK_O,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  output logic [NUM_IRQ-1:0] irq_bus_o,
  output logic               irq_o
);
  logic [NUM_IRQ-1:0] s, rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] dat_q, dat_d;
  logic               ack_q, ack_d;
  logic [NUM_IRQ-1:0] clr, rdata;
  logic               acc, wr, rd;

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_IRQ-1:0] (
    .clk    (CLK_I),
    .rst    (RST_I),
    .raw_i  (irq_raw_i),
    .s_o    (s),
    .rise_o (rise)
  );

  always_comb begin
    // ~ack_q spaces back-to-back accesses under a held strobe.
    acc    = CYC_I & STB_I & ~ack_q;
    wr     = acc & WE_I;
    rd     = acc & ~WE_I;
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr) begin
      case (ADR_I)
        IRQ_ADR_PENDING: clr    = DAT_I;
        IRQ_ADR_MASK:    mask_d = DAT_I;
        IRQ_ADR_MODE:    mode_d = DAT_I;
        default:         ;
      endcase
    end
    case (ADR_I)
      IRQ_ADR_PENDING: rdata = pending_q;
      IRQ_ADR_MASK:    rdata = mask_q;
      IRQ_ADR_MODE:    rdata = mode_q;
      default:         rdata = s;
    endcase
    // Edge lines: set beats same-cycle clear. Level lines: follow s.
    pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & s);
    dat_d     = rd ? rdata : dat_q;
    ack_d     = acc;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
    end
  end

  assign DAT_O     = dat_q;
  assign ACK_O     = ack_q;
  assign irq_bus_o = pending_q & mask_q;
  assign irq_o     = |irq_bus_o;
endmodule

// File: tb/tb_irq_source_latch.sv
// Directed bench for irq_source_latch: register table, level-mode table, and
// hand-written sequences for edge latency, set/clear collision, masking, held strobe, reset.
module tb_irq_source_latch;
  logic       CLK_I = 1'b0;
  logic       RST_I, CYC_I, STB_I, WE_I;
  logic [1:0] ADR_I;
  logic [7:0] DAT_I, DAT_O, irq_raw_i, irq_bus_o;
  logic       ACK_O, irq_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_source_latch dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .irq_raw_i(irq_raw_i), .irq_bus_o(irq_bus_o), .irq_o(irq_o)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct { logic [1:0] adr; logic [7:0] wdat; logic [7:0] exp; } reg_vec_t;
  typedef struct { logic [7:0] raw; logic [7:0] exp; } lvl_vec_t;

  reg_vec_t rv[4];
  lvl_vec_t lv[4];

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 2'd0; DAT_I = 8'h00;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; DAT_I = dat;
    tick();
    check("wr_ack", {7'd0, ACK_O}, 8'h01);
    bus_idle();
    tick();
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] dat);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr;
    tick();
    check("rd_ack", {7'd0, ACK_O}, 8'h01);
    dat = DAT_O;
    bus_idle();
    tick();
    check("ack_drop", {7'd0, ACK_O}, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] prev;
    int acks;
    logic last_ack;

    rv[0] = '{2'd1, 8'h5A, 8'h5A};
    rv[1] = '{2'd2, 8'h3C, 8'h3C};
    rv[2] = '{2'd3, 8'hFF, 8'h00};
    rv[3] = '{2'd0, 8'hFF, 8'h00};
    lv[0] = '{8'hA0, 8'hA0};
    lv[1] = '{8'h00, 8'h00};
    lv[2] = '{8'h5F, 8'h5F};
    lv[3] = '{8'h00, 8'h00};

    bus_idle();
    irq_raw_i = 8'h00;
    RST_I = 1'b1;
    tick(); tick();
    RST_I = 1'b0;
    check("rst_ack", {7'd0, ACK_O}, 8'h00);
    check("rst_dat", DAT_O, 8'h00);
    check("rst_bus", irq_bus_o, 8'h00);
    for (int a = 0; a < 4; a++) begin
      wb_read(a[1:0], d);
      check($sformatf("rst_reg%0d", a), d, 8'h00);
    end
    check("rst_irq", {7'd0, irq_o}, 8'h00);

    // Register write/readback table
    for (int i = 0; i < 4; i++) begin
      wb_write(rv[i].adr, rv[i].wdat);
      wb_read(rv[i].adr, d);
      check($sformatf("reg_rw%0d", i), d, rv[i].exp);
    end

    // Edge mode, line 0: 3-edge latency, hold, w1c
    wb_write(2'd2, 8'h01);
    wb_write(2'd1, 8'h01);
    irq_raw_i = 8'h01;
    tick(); tick();
    check("edge_lat2", irq_bus_o, 8'h00);
    tick();
    check("edge_lat3", irq_bus_o, 8'h01);
    check("edge_irq", {7'd0, irq_o}, 8'h01);
    irq_raw_i = 8'h00;
    repeat (4) tick();
    check("edge_hold", irq_bus_o, 8'h01);
    wb_write(2'd0, 8'h01);
    check("edge_clr", irq_bus_o, 8'h00);
    check("edge_clr_irq", {7'd0, irq_o}, 8'h00);

    // Level mode tracking table
    wb_write(2'd2, 8'h00);
    wb_write(2'd1, 8'hFF);
    prev = 8'h00;
    for (int i = 0; i < 4; i++) begin
      irq_raw_i = lv[i].raw;
      tick(); tick();
      check($sformatf("lvl_old%0d", i), irq_bus_o, prev);
      tick();
      check($sformatf("lvl_new%0d", i), irq_bus_o, lv[i].exp);
      prev = lv[i].exp;
    end
    irq_raw_i = 8'hA0;
    repeat (3) tick();
    wb_write(2'd0, 8'hFF);
    wb_read(2'd0, d);
    check("lvl_w1c_noeffect", d, 8'hA0);
    wb_read(2'd3, d);
    check("status", d, 8'hA0);
    irq_raw_i = 8'h00;
    repeat (3) tick();
    check("lvl_fall", irq_bus_o, 8'h00);

    // Edge on line 3 lands on the same edge as a PENDING clear of bit 3
    wb_write(2'd2, 8'hFF);
    irq_raw_i = 8'h08;
    tick(); tick();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; DAT_I = 8'h08;
    tick();
    bus_idle();
    tick();
    wb_read(2'd0, d);
    check("set_wins", d, 8'h08);
    wb_write(2'd0, 8'h08);
    wb_read(2'd0, d);
    check("no_spurious", d, 8'h00);
    irq_raw_i = 8'h00;

    // Masked edge on line 7, then unmask
    wb_write(2'd1, 8'h00);
    irq_raw_i = 8'h80;
    repeat (4) tick();
    wb_read(2'd0, d);
    check("mask_pend", d, 8'h80);
    check("mask_bus", irq_bus_o, 8'h00);
    check("mask_irq", {7'd0, irq_o}, 8'h00);
    wb_write(2'd1, 8'h80);
    check("unmask_bus", irq_bus_o, 8'h80);
    check("unmask_irq", {7'd0, irq_o}, 8'h01);
    irq_raw_i = 8'h00;

    // Held strobe for 4 cycles: two ACKs, never back to back
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd1;
    acks = 0;
    last_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ACK_O) acks++;
      n_cmp++;
      if (ACK_O && last_ack) begin
        n_err++;
        $display("FAIL held_double_ack: cycle %0d got ack=1 after ack=1 expected 0", c);
      end
      last_ack = ACK_O;
    end
    check("held_ack_count", acks[7:0], 8'd2);
    bus_idle();
    tick();

    // Reset during a MASK write
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd1; DAT_I = 8'hFF;
    RST_I = 1'b1;
    tick();
    check("rst_mid_ack", {7'd0, ACK_O}, 8'h00);
    bus_idle();
    RST_I = 1'b0;
    tick();
    wb_read(2'd1, d);
    check("rst_mid_mask", d, 8'h00);
    wb_read(2'd0, d);
    check("rst_mid_pend", d, 8'h00);
    check("rst_mid_bus", irq_bus_o, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
